// File: rtl/clint_timer_ctrl_if.sv
// Register-bus bundle between the core MMIO fabric and the machine-timer block.
// The master drives requests. The slave answers with exactly one response per accepted request.
// ready stays low while a response is outstanding.
interface clint_timer_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rsp_valid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rsp_valid, bus_rdata, bus_err
  );
endinterface

// File: rtl/clint_timer_ctrl.sv
// Machine timer: mtime/mtimecmp/prescaler/msip with a 32-bit register bus and registered irqs.
// Latency: a bus response arrives one clk after accept, and irqs follow their condition by one clk.
// Backpressure: bus_ready is low during the response cycle, so at most one access is accepted every 2 clks.
module clint_timer_ctrl #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  clint_timer_ctrl_if.slave   bus,
  output logic [63:0]         mtime_o,
  output logic                timer_irq,
  output logic                soft_irq
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q;
  logic             en_q, irq_en_q, msip_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_shadow_q;
  logic             rsp_vld_q, err_q, tirq_q, sirq_q;
  logic [31:0]      rdata_q;

  logic             accept, addr_err, tick;
  logic             wr_lo, wr_hi, wr_clo, wr_chi, wr_ctrl, wr_msip, rd_lo;
  logic [31:0]      rd_dat, ctrl_rd;

  assign bus.bus_ready     = ~rsp_vld_q;
  assign bus.bus_rsp_valid = rsp_vld_q;
  assign bus.bus_rdata     = rdata_q;
  assign bus.bus_err       = err_q;
  assign mtime_o           = mtime_q;
  assign timer_irq         = tirq_q;
  assign soft_irq          = sirq_q;

  assign accept = bus.bus_req & ~rsp_vld_q;
  assign tick   = en_q & (cnt_q == div_q);

  // Address decode, write strobes and read mux for the accepted access
  always_comb begin
    addr_err = (bus.bus_addr[1:0] != 2'b00) || (bus.bus_addr > 5'h14);
    wr_lo    = 1'b0;
    wr_hi    = 1'b0;
    wr_clo   = 1'b0;
    wr_chi   = 1'b0;
    wr_ctrl  = 1'b0;
    wr_msip  = 1'b0;
    rd_lo    = 1'b0;
    ctrl_rd  = '0;
    ctrl_rd[8 +: DIV_W] = div_q;
    ctrl_rd[1] = irq_en_q;
    ctrl_rd[0] = en_q;
    rd_dat   = '0;
    if (accept && !addr_err) begin
      case (bus.bus_addr[4:2])
        3'd0: begin
          wr_lo  = bus.bus_we;
          rd_lo  = ~bus.bus_we;
          rd_dat = mtime_q[31:0];
        end
        3'd1: begin
          wr_hi  = bus.bus_we;
          rd_dat = hi_shadow_q;
        end
        3'd2: begin
          wr_clo = bus.bus_we;
          rd_dat = cmp_q[31:0];
        end
        3'd3: begin
          wr_chi = bus.bus_we;
          rd_dat = cmp_q[63:32];
        end
        3'd4: begin
          wr_ctrl = bus.bus_we;
          rd_dat  = ctrl_rd;
        end
        default: begin
          wr_msip = bus.bus_we;
          rd_dat  = {31'd0, msip_q};
        end
      endcase
      if (bus.bus_we) rd_dat = '0;
    end
  end

  // mtime next value: a bus write to either half overrides the tick increment
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_lo) mtime_d = {mtime_q[63:32], bus.bus_wdata};
    if (wr_hi) mtime_d = {bus.bus_wdata, mtime_q[31:0]};
    cnt_d = cnt_q;
    if (wr_ctrl)   cnt_d = '0;
    else if (en_q) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
  end

  // Timer state, control registers and atomic-read shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q     <= '0;
      cmp_q       <= '1;
      en_q        <= 1'b0;
      irq_en_q    <= 1'b0;
      div_q       <= RST_DIV;
      msip_q      <= 1'b0;
      cnt_q       <= '0;
      hi_shadow_q <= '0;
    end else begin
      mtime_q <= mtime_d;
      cnt_q   <= cnt_d;
      if (wr_clo) cmp_q[31:0]  <= bus.bus_wdata;
      if (wr_chi) cmp_q[63:32] <= bus.bus_wdata;
      if (wr_ctrl) begin
        en_q     <= bus.bus_wdata[0];
        irq_en_q <= bus.bus_wdata[1];
        div_q    <= bus.bus_wdata[8 +: DIV_W];
      end
      if (wr_msip) msip_q <= bus.bus_wdata[0];
      if (rd_lo) hi_shadow_q <= mtime_q[63:32];
    end
  end

  // Single-cycle bus response and registered interrupt outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tirq_q    <= 1'b0;
      sirq_q    <= 1'b0;
    end else begin
      rsp_vld_q <= accept;
      rdata_q   <= rd_dat;
      err_q     <= accept & addr_err;
      tirq_q    <= irq_en_q & (mtime_q >= cmp_q);
      sirq_q    <= msip_q;
    end
  end

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Randomized and directed stimulus against a behavioural model of the timer.
// Bus responses are scoreboarded through a queue, and a separate monitor checks them.
// Timer, irq and ready outputs are compared against the model every clk.
module tb_clint_timer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clint_timer_ctrl_if bus();
  logic [63:0] mtime_o;
  logic        timer_irq, soft_irq;

  clint_timer_ctrl #(.DIV_W(8), .RESET_DIV(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mtime_o(mtime_o), .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: architectural registers plus enabled-cycle count since the last ctrl write
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow;
  logic        m_en, m_irq_en, m_msip, m_pend, m_tirq, m_sirq;
  int          m_div, m_ecnt;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    m_mtime = 64'd0;  m_cmp = '1;  m_shadow = 32'd0;
    m_en = 0; m_irq_en = 0; m_msip = 0; m_pend = 0; m_tirq = 0; m_sirq = 0;
    m_div = 0; m_ecnt = 0;
  endfunction

  // One clock: drive inputs, predict the edge, then check the outputs on the next falling edge
  task automatic cycle(input bit req, input bit we, input logic [4:0] addr, input logic [31:0] wd);
    bit          acc, aerr, tick;
    logic [31:0] rdv;
    logic [63:0] nm, nc;
    logic [31:0] nsh;
    bit          nen, nie, nms;
    int          ndiv, necnt;
    bit          ntirq, nsirq;
    bus.bus_req = req; bus.bus_we = we; bus.bus_addr = addr; bus.bus_wdata = wd;
    acc  = req && !m_pend;
    aerr = (addr % 4 != 0) || (addr > 20);
    tick = m_en && ((m_ecnt % (m_div + 1)) == m_div);
    case (int'(addr))
      0:  rdv = m_mtime[31:0];
      4:  rdv = m_shadow;
      8:  rdv = m_cmp[31:0];
      12: rdv = m_cmp[63:32];
      16: rdv = (m_div << 8) | (32'(m_irq_en) << 1) | 32'(m_en);
      20: rdv = 32'(m_msip);
      default: rdv = 32'd0;
    endcase
    if (acc) exp_q.push_back('{cyc + 1, (!we && !aerr) ? rdv : 32'd0, aerr});
    ntirq = m_irq_en && (m_mtime >= m_cmp);
    nsirq = m_msip;
    nm = tick ? m_mtime + 64'd1 : m_mtime;
    nc = m_cmp; nsh = m_shadow; nen = m_en; nie = m_irq_en; nms = m_msip; ndiv = m_div;
    necnt = m_en ? m_ecnt + 1 : m_ecnt;
    if (acc && !aerr && we) begin
      case (int'(addr))
        0:  nm = {m_mtime[63:32], wd};
        4:  nm = {wd, m_mtime[31:0]};
        8:  nc[31:0]  = wd;
        12: nc[63:32] = wd;
        16: begin nen = wd[0]; nie = wd[1]; ndiv = int'(wd[15:8]); necnt = 0; end
        default: nms = wd[0];
      endcase
    end
    if (acc && !aerr && !we && addr == 5'd0) nsh = m_mtime[63:32];
    @(posedge clk);
    m_mtime = nm; m_cmp = nc; m_shadow = nsh; m_en = nen; m_irq_en = nie; m_msip = nms;
    m_div = ndiv; m_ecnt = necnt; m_pend = acc; m_tirq = ntirq; m_sirq = nsirq;
    @(negedge clk);
    chk("mtime", mtime_o, m_mtime);
    chk("timer_irq", 64'(timer_irq), 64'(m_tirq));
    chk("soft_irq", 64'(soft_irq), 64'(m_sirq));
    chk("bus_ready", 64'(bus.bus_ready), 64'(!m_pend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 32'd0);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(1, 1, a, d); idle(1);
  endtask
  task automatic rd(input logic [4:0] a);
    cycle(1, 0, a, 32'd0); idle(1);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        $display("FAIL rsp_missing: no response seen, expected at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (bus.bus_rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: got bus_rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_rdata", 64'(bus.bus_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(bus.bus_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    int          r;
    bus.bus_req = 0; bus.bus_we = 0; bus.bus_addr = '0; bus.bus_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mtime", mtime_o, 64'd0);
    chk("rst_timer_irq", 64'(timer_irq), 64'd0);
    chk("rst_soft_irq", 64'(soft_irq), 64'd0);
    chk("rst_rsp_valid", 64'(bus.bus_rsp_valid), 64'd0);
    chk("rst_rdata", 64'(bus.bus_rdata), 64'd0);
    chk("rst_err", 64'(bus.bus_err), 64'd0);
    rst_n = 1'b1;
    idle(2);
    rd(5'h08); rd(5'h0C); rd(5'h10); rd(5'h14);

    // cmp=10, div=0, count from 0 with the irq enabled, then raise cmp as the ack
    wr(5'h08, 32'd10); wr(5'h0C, 32'd0); wr(5'h04, 32'd0); wr(5'h00, 32'd0);
    wr(5'h10, 32'h3);
    idle(14);
    wr(5'h08, 32'd200); idle(2);

    // div=3 then freeze
    wr(5'h10, 32'h303); idle(12);
    wr(5'h10, 32'h300); idle(5); rd(5'h00);

    // carry into the high word and shadow coherence
    wr(5'h04, 32'd0); wr(5'h00, 32'hFFFF_FFFF); wr(5'h10, 32'h1);
    idle(1); rd(5'h00); rd(5'h04);
    wr(5'h10, 32'h0); wr(5'h00, 32'hFFFF_FFFF); wr(5'h04, 32'd0); wr(5'h10, 32'h301);
    rd(5'h00); idle(4); rd(5'h04);

    // mtime_lo write during tick cycles (div=0 ticks every clk)
    wr(5'h10, 32'h1); wr(5'h00, 32'h1234); rd(5'h00); wr(5'h04, 32'h55); rd(5'h00); rd(5'h04);

    // all-ones compare, then wrap to zero
    wr(5'h10, 32'h0);
    wr(5'h08, '1); wr(5'h0C, '1); wr(5'h00, '1); wr(5'h04, '1);
    wr(5'h10, 32'h2); idle(3);
    wr(5'h10, 32'h3); idle(4);

    // bad addresses and msip
    rd(5'h02); rd(5'h18); wr(5'h02, '1); wr(5'h19, '1); wr(5'h1C, '1);
    rd(5'h08); rd(5'h10);
    wr(5'h14, 32'h1); idle(2); rd(5'h14); wr(5'h14, 32'h0); idle(2);

    // randomized traffic, with req sometimes held through the response cycle
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 15));
      a = (r < 12) ? 5'((r % 6) * 4) : 5'($urandom);
      d = $urandom;
      if (a == 5'h10) d = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 1) | 32'(($urandom % 5) != 0);
      else if (a == 5'h08) d = m_mtime[31:0] + $urandom_range(0, 20);
      else if (a == 5'h0C) d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : m_mtime[63:32];
      else if (a == 5'h04) d = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      else if (a == 5'h00) d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 100);
      cycle(($urandom % 3) != 0, $urandom_range(0, 1) == 1, a, d);
    end
    idle(3);

    // reset with a response outstanding: it must be dropped
    cycle(0, 0, 5'd0, 32'd0);
    bus.bus_req = 1; bus.bus_we = 0; bus.bus_addr = 5'h08;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.bus_req = 0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("rst_mid_rsp_valid", 64'(bus.bus_rsp_valid), 64'd0);
    chk("rst_mid_mtime", mtime_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    rd(5'h10); rd(5'h08);

    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
